// File: rtl/rnd_dup_checker_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : rnd_dup_checker_if
// Brief    : Bus bundle between the duplicate checker, its RAM read port
//            and the controlling system (start/status/results).
// Revision : 1.0
// ---------------------------------------------------------------------------
interface rnd_dup_checker_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int COUNT_W    = 16
);
  logic                  start;
  logic                  rd_o;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  busy;
  logic                  done;
  logic [COUNT_W-1:0]    dup_count;
  logic                  dup_found;
  logic [ADDR_WIDTH-1:0] dup_addr_a;
  logic [ADDR_WIDTH-1:0] dup_addr_b;

  // System side: issues start, returns RAM data, observes status/results
  modport master (
    output start, data_i,
    input  rd_o, addr_o, busy, done, dup_count, dup_found, dup_addr_a, dup_addr_b
  );

  // Checker side
  modport slave (
    input  start, data_i,
    output rd_o, addr_o, busy, done, dup_count, dup_found, dup_addr_a, dup_addr_b
  );
endinterface
`default_nettype wire

// File: rtl/rnd_dup_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : rnd_dup_checker
// Brief    : Walks RAM addresses 0..RAM_DEPTH-1 through a 1-cycle-latency
//            read port and counts unordered equal word pairs (i<j), keeping
//            the first pair seen and pulsing done at the end of a pass.
// Revision : 1.0
// ---------------------------------------------------------------------------
module rnd_dup_checker #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RAM_DEPTH  = 100,
  parameter int COUNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  rnd_dup_checker_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REF  = 3'd1,
    CAP_REF = 3'd2,
    RD_CMP  = 3'd3,
    CMP     = 3'd4,
    FIN     = 3'd5
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] C_LAST   = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] C_PENULT = ADDR_WIDTH'(RAM_DEPTH - 2);
  localparam logic [COUNT_W-1:0]    C_SAT    = '1;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_i;
  logic [ADDR_WIDTH-1:0] r_j;
  logic [DATA_WIDTH-1:0] r_ref;
  logic [COUNT_W-1:0]    r_count;
  logic                  r_found;
  logic [ADDR_WIDTH-1:0] r_addr_a;
  logic [ADDR_WIDTH-1:0] r_addr_b;
  logic [ADDR_WIDTH-1:0] r_last_addr;
  logic                  w_rd;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_match;

  assign w_match = (bus.data_i == r_ref);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state and read-port decode; address holds its last value when idle
  always_comb begin
    w_next = r_state;
    w_rd   = 1'b0;
    w_addr = r_last_addr;
    case (r_state)
      IDLE:    if (bus.start) w_next = RD_REF;
      RD_REF: begin
        w_rd   = 1'b1;
        w_addr = r_i;
        w_next = CAP_REF;
      end
      CAP_REF: w_next = RD_CMP;
      RD_CMP: begin
        w_rd   = 1'b1;
        w_addr = r_j;
        w_next = CMP;
      end
      CMP: begin
        if (r_j < C_LAST)        w_next = RD_CMP;
        else if (r_i < C_PENULT) w_next = RD_REF;
        else                     w_next = FIN;
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Pair indices, reference word and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i         <= '0;
      r_j         <= '0;
      r_ref       <= '0;
      r_count     <= '0;
      r_found     <= 1'b0;
      r_addr_a    <= '0;
      r_addr_b    <= '0;
      r_last_addr <= '0;
    end else begin
      r_last_addr <= w_addr;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_i      <= '0;
            r_count  <= '0;
            r_found  <= 1'b0;
            r_addr_a <= '0;
            r_addr_b <= '0;
          end
        end
        CAP_REF: begin
          r_ref <= bus.data_i;
          r_j   <= r_i + 1'b1;
        end
        CMP: begin
          if (w_match) begin
            if (r_count != C_SAT) r_count <= r_count + 1'b1;
            if (!r_found) begin
              r_found  <= 1'b1;
              r_addr_a <= r_i;
              r_addr_b <= r_j;
            end
          end
          if (r_j < C_LAST)        r_j <= r_j + 1'b1;
          else if (r_i < C_PENULT) r_i <= r_i + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.rd_o       = w_rd;
  assign bus.addr_o     = w_addr;
  assign bus.busy       = (r_state != IDLE) && (r_state != FIN);
  assign bus.done       = (r_state == FIN);
  assign bus.dup_count  = r_count;
  assign bus.dup_found  = r_found;
  assign bus.dup_addr_a = r_addr_a;
  assign bus.dup_addr_b = r_addr_b;

endmodule
`default_nettype wire

// File: tb/tb_rnd_dup_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_rnd_dup_checker
// Brief    : Self-checking bench for rnd_dup_checker: two 4-word checkers
//            (16-bit and 2-bit counters) share one RAM image, and a 100-word
//            checker covers the full-size pass.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_rnd_dup_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rnd_dup_checker_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .COUNT_W(16)) ia ();
  rnd_dup_checker_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .COUNT_W(2))  ib ();
  rnd_dup_checker_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .COUNT_W(16)) ic ();

  rnd_dup_checker #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RAM_DEPTH(4), .COUNT_W(16))
    dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  rnd_dup_checker #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RAM_DEPTH(4), .COUNT_W(2))
    dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
  rnd_dup_checker #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RAM_DEPTH(100), .COUNT_W(16))
    dut_c (.clk(clk), .rst(rst), .bus(ic.slave));

  // RAM images with 1-cycle read latency
  logic [31:0] ram4   [4];
  logic [31:0] ram100 [100];
  always @(posedge clk) if (ia.rd_o) ia.data_i <= ram4[ia.addr_o[1:0]];
  always @(posedge clk) if (ib.rd_o) ib.data_i <= ram4[ib.addr_o[1:0]];
  always @(posedge clk) if (ic.rd_o) ic.data_i <= ram100[ic.addr_o[6:0]];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: count equal pairs i<j, first pair in scan order, saturate at 2^cw-1
  function automatic void model(input logic [31:0] v[$], input int cw,
                                output int cnt, output int fa, output int fb, output bit fnd);
    longint pairs = 0;
    longint sat;
    fa = 0; fb = 0; fnd = 1'b0;
    for (int i = 0; i < v.size(); i++)
      for (int j = i + 1; j < v.size(); j++)
        if (v[i] == v[j]) begin
          pairs++;
          if (!fnd) begin fnd = 1'b1; fa = i; fb = j; end
        end
    sat = (longint'(1) << cw) - 1;
    cnt = int'((pairs > sat) ? sat : pairs);
  endfunction

  // Expected per-cycle trace of the 4-word checkers
  typedef struct {
    bit busy; bit done; bit rd; int addr;
    int cnt_a; int cnt_b; int fa; int fb; bit found;
  } ent_t;
  ent_t exp_q[$];

  function automatic ent_t mk(input bit busy, input bit done, input bit rd, input int addr);
    ent_t e;
    e.busy = busy; e.done = done; e.rd = rd; e.addr = addr;
    e.cnt_a = 0; e.cnt_b = 0; e.fa = 0; e.fb = 0; e.found = 1'b0;
    return e;
  endfunction

  // A pass reads each reference i once, then every j>i once, one idle cycle after each read
  task automatic push_pass(input int n, input int ca, input int cb,
                           input int fa, input int fb, input bit fnd);
    ent_t e;
    for (int i = 0; i < n - 1; i++) begin
      exp_q.push_back(mk(1, 0, 1, i));
      exp_q.push_back(mk(1, 0, 0, i));
      for (int j = i + 1; j < n; j++) begin
        exp_q.push_back(mk(1, 0, 1, j));
        exp_q.push_back(mk(1, 0, 0, j));
      end
    end
    e = mk(0, 1, 0, n - 1);
    e.cnt_a = ca; e.cnt_b = cb; e.fa = fa; e.fb = fb; e.found = fnd;
    exp_q.push_back(e);
  endtask

  // Compare process: every cycle against the trace / held results
  int h_cnt_a = 0, h_cnt_b = 0, h_fa = 0, h_fb = 0, last_addr = 0;
  bit h_found = 1'b0;
  int c_busy = 0;
  bit c_seen = 1'b0;
  int c_cnt = 0, c_fa = 0, c_fb = 0;
  bit c_fnd = 1'b0;

  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        h_cnt_a = 0; h_cnt_b = 0; h_fa = 0; h_fb = 0; h_found = 1'b0;
        last_addr = 0; c_busy = 0;
        chk("rst_busy", 64'(ia.busy), 0);
        chk("rst_done", 64'(ia.done), 0);
        chk("rst_rd", 64'(ia.rd_o), 0);
        chk("rst_addr", 64'(ia.addr_o), 0);
        chk("rst_count", 64'(ia.dup_count), 0);
        chk("rst_found", 64'(ia.dup_found), 0);
        chk("rst_addr_a", 64'(ia.dup_addr_a), 0);
        chk("rst_addr_b", 64'(ia.dup_addr_b), 0);
        chk("rst_b_busy", 64'(ib.busy), 0);
        chk("rst_b_count", 64'(ib.dup_count), 0);
        chk("rst_c_busy", 64'(ic.busy), 0);
      end else begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = mk(0, 0, 0, last_addr);
        last_addr = e.addr;
        chk("a_busy", 64'(ia.busy), 64'(e.busy));
        chk("a_done", 64'(ia.done), 64'(e.done));
        chk("a_rd", 64'(ia.rd_o), 64'(e.rd));
        chk("a_addr", 64'(ia.addr_o), 64'(e.addr));
        chk("b_busy", 64'(ib.busy), 64'(e.busy));
        chk("b_done", 64'(ib.done), 64'(e.done));
        chk("b_rd", 64'(ib.rd_o), 64'(e.rd));
        chk("b_addr", 64'(ib.addr_o), 64'(e.addr));
        if (e.done) begin
          h_cnt_a = e.cnt_a; h_cnt_b = e.cnt_b;
          h_fa = e.fa; h_fb = e.fb; h_found = e.found;
        end
        if (!e.busy) begin
          chk("a_count", 64'(ia.dup_count), 64'(h_cnt_a));
          chk("a_found", 64'(ia.dup_found), 64'(h_found));
          chk("a_addr_a", 64'(ia.dup_addr_a), 64'(h_fa));
          chk("a_addr_b", 64'(ia.dup_addr_b), 64'(h_fb));
          chk("b_count", 64'(ib.dup_count), 64'(h_cnt_b));
          chk("b_found", 64'(ib.dup_found), 64'(h_found));
        end
        if (ic.busy) c_busy++;
        if (ic.done) begin
          chk("c_busy_cycles", 64'(c_busy), 64'(10098));
          chk("c_count", 64'(ic.dup_count), 64'(c_cnt));
          chk("c_found", 64'(ic.dup_found), 64'(c_fnd));
          chk("c_addr_a", 64'(ic.dup_addr_a), 64'(c_fa));
          chk("c_addr_b", 64'(ic.dup_addr_b), 64'(c_fb));
          c_seen = 1'b1;
          c_busy = 0;
        end
      end
    end
  end

  task automatic drain(input string nm);
    for (int k = 0; k < 300; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk(nm, 64'(exp_q.size()), 0);
  endtask

  // Load RAM, queue the expected trace and launch one pass on both 4-word checkers
  task automatic launch4(input logic [31:0] v0, input logic [31:0] v1,
                         input logic [31:0] v2, input logic [31:0] v3,
                         output int ca, output int cb, output int fa, output int fb);
    logic [31:0] v[$];
    bit fnd;
    int d0, d1;
    bit d2;
    v = '{v0, v1, v2, v3};
    model(v, 16, ca, fa, fb, fnd);
    model(v, 2, cb, d0, d1, d2);
    @(negedge clk); #1;
    for (int k = 0; k < 4; k++) ram4[k] = v[k];
    push_pass(4, ca, cb, fa, fb, fnd);
    ia.start = 1'b1; ib.start = 1'b1;
    @(posedge clk); #1;
    ia.start = 1'b0; ib.start = 1'b0;
  endtask

  task automatic pass4(input logic [31:0] v0, input logic [31:0] v1,
                       input logic [31:0] v2, input logic [31:0] v3, input bit poke,
                       output int ca, output int cb, output int fa, output int fb);
    launch4(v0, v1, v2, v3, ca, cb, fa, fb);
    if (poke) begin
      repeat (6) @(posedge clk);
      #1; ia.start = 1'b1; ib.start = 1'b1;
      @(posedge clk); #1; ia.start = 1'b0; ib.start = 1'b0;
    end
    drain("pass_drain");
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int ca, cb, fa, fb;
    longint seq;
    int nb;
    logic [31:0] v[$];

    ia.start = 1'b0; ib.start = 1'b0; ic.start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    // Pin the trace model: busy length and read address order for depth 4
    push_pass(4, 0, 0, 0, 0, 1'b0);
    seq = 0; nb = 0;
    foreach (exp_q[k]) begin
      if (exp_q[k].busy) nb++;
      if (exp_q[k].rd) seq = seq * 10 + exp_q[k].addr;
    end
    exp_q.delete();
    chk("model_busy_len", 64'(nb), 18);
    chk("model_rd_trace", 64'(seq), 64'(12312323));

    // Directed patterns with literal expectations
    pass4(1, 2, 3, 4, 1'b0, ca, cb, fa, fb);
    chk("lit_distinct_cnt", 64'(ca), 0);
    pass4(7, 9, 7, 5, 1'b1, ca, cb, fa, fb);
    chk("lit_one_cnt", 64'(ca), 1);
    chk("lit_one_a", 64'(fa), 0);
    chk("lit_one_b", 64'(fb), 2);
    pass4(5, 5, 5, 5, 1'b0, ca, cb, fa, fb);
    chk("lit_all_cnt", 64'(ca), 6);
    chk("lit_all_sat", 64'(cb), 3);
    chk("lit_all_b", 64'(fb), 1);

    // start held high through done: second pass follows after one idle cycle
    @(negedge clk); #1;
    v = '{32'd3, 32'd8, 32'd8, 32'd3};
    for (int k = 0; k < 4; k++) ram4[k] = v[k];
    begin
      bit fnd;
      int d0, d1;
      bit d2;
      model(v, 16, ca, fa, fb, fnd);
      model(v, 2, cb, d0, d1, d2);
      push_pass(4, ca, cb, fa, fb, fnd);
      exp_q.push_back(mk(0, 0, 0, 3));
      push_pass(4, ca, cb, fa, fb, fnd);
    end
    ia.start = 1'b1; ib.start = 1'b1;
    repeat (21) @(posedge clk);
    #1; ia.start = 1'b0; ib.start = 1'b0;
    drain("hold_drain");

    // Reset five cycles into a pass, then a clean restart
    launch4(4, 4, 1, 4, ca, cb, fa, fb);
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle_q", 64'(exp_q.size()), 0);
    pass4(4, 4, 1, 4, 1'b0, ca, cb, fa, fb);

    // Randomized small-alphabet passes
    for (int it = 0; it < 10; it++)
      pass4($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), bit'($urandom_range(0, 1)), ca, cb, fa, fb);

    // Full-size pass
    v.delete();
    for (int k = 0; k < 100; k++) begin
      ram100[k] = $urandom_range(0, 63);
      v.push_back(ram100[k]);
    end
    model(v, 16, c_cnt, c_fa, c_fb, c_fnd);
    @(negedge clk); #1 ic.start = 1'b1;
    @(posedge clk); #1 ic.start = 1'b0;
    for (int k = 0; k < 10300; k++) begin
      if (c_seen) break;
      @(negedge clk);
    end
    chk("c_done_seen", 64'(c_seen), 1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
